// File: rtl/timer_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : timer_seq_pkg
// Desc   : Shared timer register map, control/status bit positions and the
//          sequencer state encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package timer_seq_pkg;

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_AR   = 3'd1;
    localparam logic [2:0] REG_CNTR = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IE  = 1;
    localparam int STAT_OVF = 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_W_OFF = 4'd1;
    localparam logic [3:0] S_W_AR  = 4'd2;
    localparam logic [3:0] S_W_CNT = 4'd3;
    localparam logic [3:0] S_W_CLR = 4'd4;
    localparam logic [3:0] S_W_EN  = 4'd5;
    localparam logic [3:0] S_RUN   = 4'd6;
    localparam logic [3:0] S_ACK   = 4'd7;
    localparam logic [3:0] S_CHK   = 4'd8;
    localparam logic [3:0] S_FIN   = 4'd9;

endpackage

`default_nettype wire

// File: rtl/timer_seq_if.sv
//------------------------------------------------------------------------------
// Module : timer_seq_if
// Desc   : Register-port bus between the sequencer (master) and the timer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface timer_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             t_cs;
    logic             t_wen;
    logic [2:0]       t_addr;
    logic [WIDTH-1:0] t_din;
    logic             t_irq;

    modport master (output t_cs, output t_wen, output t_addr, output t_din, input  t_irq);
    modport slave  (input  t_cs, input  t_wen, input  t_addr, input  t_din, output t_irq);
endinterface

`default_nettype wire

// File: rtl/timer_seq.sv
//------------------------------------------------------------------------------
// Module : timer_seq
// Desc   : Programs a timer, counts acknowledged overflows and stops it after
//          a programmed number of periods or on request.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_seq
    import timer_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic [WIDTH-1:0] period,
    input  wire logic [CNT_W-1:0] reps,
    timer_seq_if.master           tbus,
    output logic                  busy,
    output logic                  tick,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      remaining
);

    localparam logic [WIDTH-1:0] c_CTRL_ON  = (WIDTH'(1) << CTRL_EN) | (WIDTH'(1) << CTRL_IE);
    localparam logic [WIDTH-1:0] c_STAT_CLR = WIDTH'(1) << STAT_OVF;

    logic [3:0]       r_state;
    logic [WIDTH-1:0] r_period;
    logic [CNT_W-1:0] r_reps;
    logic [CNT_W-1:0] r_remaining;
    logic             r_aborted;
    logic             r_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_period    <= '0;
            r_reps      <= '0;
            r_remaining <= '0;
            r_aborted   <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop && (period != '0)) begin
                        r_period    <= period;
                        r_reps      <= reps;
                        r_remaining <= reps;
                        r_aborted   <= 1'b0;
                        r_state     <= S_W_OFF;
                    end
                end
                S_FIN: r_state <= S_IDLE;
                default: begin
                    // Abort takes priority over any overflow seen in the same cycle
                    if (stop) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        case (r_state)
                            S_W_OFF: r_state <= S_W_AR;
                            S_W_AR:  r_state <= S_W_CNT;
                            S_W_CNT: r_state <= S_W_CLR;
                            S_W_CLR: r_state <= S_W_EN;
                            S_W_EN:  r_state <= S_RUN;
                            S_RUN: begin
                                if (tbus.t_irq) begin
                                    r_tick <= 1'b1;
                                    if (r_remaining != '0)
                                        r_remaining <= r_remaining - 1'b1;
                                    r_state <= S_ACK;
                                end
                            end
                            S_ACK: r_state <= S_CHK;
                            S_CHK: begin
                                // Flag re-set while the counter sits at AR: clear again, no tick
                                if (tbus.t_irq)
                                    r_state <= S_ACK;
                                else if ((r_reps == '0) || (r_remaining != '0))
                                    r_state <= S_RUN;
                                else
                                    r_state <= S_FIN;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        tbus.t_cs   = 1'b0;
        tbus.t_wen  = 1'b0;
        tbus.t_addr = 3'd0;
        tbus.t_din  = '0;
        case (r_state)
            S_W_OFF: begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_CTRL; tbus.t_din = '0;         end
            S_W_AR:  begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_AR;   tbus.t_din = r_period;   end
            S_W_CNT: begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_CNTR; tbus.t_din = '0;         end
            S_W_CLR: begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_STAT; tbus.t_din = c_STAT_CLR; end
            S_W_EN:  begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_CTRL; tbus.t_din = c_CTRL_ON;  end
            S_ACK:   begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_STAT; tbus.t_din = c_STAT_CLR; end
            S_FIN:   begin tbus.t_cs = 1'b1; tbus.t_wen = 1'b1; tbus.t_addr = REG_CTRL; tbus.t_din = '0;         end
            default: ;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign tick      = r_tick;
    assign aborted   = r_aborted;
    assign remaining = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_timer_seq.sv
//------------------------------------------------------------------------------
// Module : tb_timer_seq
// Desc   : Directed self-checking bench for timer_seq; t_irq is driven directly.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_seq;
    import timer_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic [15:0] reps;
    logic        busy, tick, done, aborted;
    logic [15:0] remaining;
    int          n_pass = 0;
    int          n_chk  = 0;

    timer_seq_if #(.WIDTH(32)) bus ();

    timer_seq #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .reps      (reps),
        .tbus      (bus.master),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic [2:0] a, input logic [31:0] d);
        chk({tag, ".cs"},   {31'd0, bus.t_cs},  {31'd0, cs});
        chk({tag, ".wen"},  {31'd0, bus.t_wen}, {31'd0, cs});
        chk({tag, ".addr"}, {29'd0, bus.t_addr}, {29'd0, a});
        chk({tag, ".din"},  bus.t_din, d);
    endtask

    // Issue an accepted start and advance to the first RUN cycle
    task automatic run_to(input logic [31:0] p, input logic [15:0] r);
        start = 1'b1; period = p; reps = r;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("run.busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; period = '0; reps = '0;
        bus.t_irq = 1'b0;
        repeat (2) cyc();
        chk_bus("rst", 1'b0, 3'd0, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.rem",  {16'd0, remaining}, 32'd0);
        chk("rst.abt",  {31'd0, aborted}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // Basic run: period=4, reps=3
        start = 1'b1; period = 32'd4; reps = 16'd3;
        cyc(); start = 1'b0;
        chk_bus("w_off", 1'b1, 3'd0, 32'd0);
        chk("w_off.busy", {31'd0, busy}, 32'd1);
        cyc(); chk_bus("w_ar",  1'b1, 3'd1, 32'd4);
        cyc(); chk_bus("w_cnt", 1'b1, 3'd2, 32'd0);
        cyc(); chk_bus("w_clr", 1'b1, 3'd3, 32'd2);
        cyc(); chk_bus("w_en",  1'b1, 3'd0, 32'd3);
        cyc(); chk_bus("run",   1'b0, 3'd0, 32'd0);
        chk("run.rem", {16'd0, remaining}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            repeat (2) cyc();
            chk("run.notick", {31'd0, tick}, 32'd0);
            bus.t_irq = 1'b1;
            cyc(); bus.t_irq = 1'b0;
            chk("ack.tick", {31'd0, tick}, 32'd1);
            chk("ack.rem", {16'd0, remaining}, 32'(2 - i));
            chk_bus("ack", 1'b1, 3'd3, 32'd2);
            cyc();
            chk("chk.tick", {31'd0, tick}, 32'd0);
            chk("chk.done", {31'd0, done}, 32'd0);
            cyc();
        end
        chk("fin.done", {31'd0, done}, 32'd1);
        chk_bus("fin", 1'b1, 3'd0, 32'd0);
        chk("fin.abt", {31'd0, aborted}, 32'd0);
        cyc();
        chk("idle.busy", {31'd0, busy}, 32'd0);
        chk("idle.done", {31'd0, done}, 32'd0);

        // Continuous mode: reps=0, period=2, ten overflows then stop
        run_to(32'd2, 16'd0);
        for (int i = 0; i < 10; i++) begin
            bus.t_irq = 1'b1;
            cyc(); bus.t_irq = 1'b0;
            chk("cont.tick", {31'd0, tick}, 32'd1);
            chk("cont.rem", {16'd0, remaining}, 32'd0);
            cyc(); cyc();
            chk("cont.busy", {31'd0, busy}, 32'd1);
        end
        stop = 1'b1;
        cyc(); stop = 1'b0;
        chk("cont.done", {31'd0, done}, 32'd1);
        chk("cont.abt", {31'd0, aborted}, 32'd1);
        chk_bus("cont.fin", 1'b1, 3'd0, 32'd0);
        cyc();
        chk("cont.idle", {31'd0, busy}, 32'd0);

        // Slow timer: irq stays high across CHK, re-ack without extra tick
        run_to(32'd1, 16'd1);
        chk("slow.abtclr", {31'd0, aborted}, 32'd0);
        bus.t_irq = 1'b1;
        cyc(); chk("slow.tick1", {31'd0, tick}, 32'd1);
        chk("slow.rem", {16'd0, remaining}, 32'd0);
        cyc(); chk("slow.chk.tick", {31'd0, tick}, 32'd0);
        cyc(); chk("slow.reack.tick", {31'd0, tick}, 32'd0);
        chk_bus("slow.reack", 1'b1, 3'd3, 32'd2);
        bus.t_irq = 1'b0;
        cyc(); chk("slow.chk2.done", {31'd0, done}, 32'd0);
        cyc(); chk("slow.done", {31'd0, done}, 32'd1);
        chk("slow.abt", {31'd0, aborted}, 32'd0);
        cyc();

        // stop coincident with irq in RUN
        run_to(32'd5, 16'd2);
        bus.t_irq = 1'b1; stop = 1'b1;
        cyc(); bus.t_irq = 1'b0; stop = 1'b0;
        chk("stopirq.tick", {31'd0, tick}, 32'd0);
        chk("stopirq.rem", {16'd0, remaining}, 32'd2);
        chk("stopirq.done", {31'd0, done}, 32'd1);
        chk("stopirq.abt", {31'd0, aborted}, 32'd1);
        cyc();
        chk("stopirq.idle", {31'd0, busy}, 32'd0);

        // Rejected starts: period=0, and start with stop together
        start = 1'b1; period = 32'd0; reps = 16'd4;
        cyc();
        chk("p0.busy", {31'd0, busy}, 32'd0);
        chk_bus("p0", 1'b0, 3'd0, 32'd0);
        stop = 1'b1; period = 32'd3;
        cyc(); start = 1'b0; stop = 1'b0;
        chk("ss.busy", {31'd0, busy}, 32'd0);
        chk("ss.abt", {31'd0, aborted}, 32'd1);

        // start while busy is ignored
        start = 1'b1; period = 32'd7; reps = 16'd1;
        cyc();
        period = 32'd9;
        cyc(); start = 1'b0;
        chk_bus("busystart.ar", 1'b1, 3'd1, 32'd7);
        repeat (4) cyc();
        chk_bus("busystart.run", 1'b0, 3'd0, 32'd0);
        chk("busystart.rem", {16'd0, remaining}, 32'd1);
        stop = 1'b1;
        cyc(); stop = 1'b0;
        cyc();

        // Asynchronous reset mid-run
        run_to(32'd4, 16'd3);
        bus.t_irq = 1'b1;
        cyc(); bus.t_irq = 1'b0;
        cyc(); cyc();
        chk("prerst.rem", {16'd0, remaining}, 32'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.rem", {16'd0, remaining}, 32'd0);
        chk_bus("midrst", 1'b0, 3'd0, 32'd0);
        cyc();
        reset_n = 1'b1;
        start = 1'b1; period = 32'd6; reps = 16'd1;
        cyc(); start = 1'b0;
        chk_bus("postrst.off", 1'b1, 3'd0, 32'd0);
        cyc();
        chk_bus("postrst.ar", 1'b1, 3'd1, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
